// File: rtl/tpu_pkg.sv
// Shared definitions for the TPU operand path: datapath widths and the
// feeder controller state encoding.
package tpu_pkg;

   localparam int DATA_W = 16;
   localparam int ACC_W  = 32;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CLEAR = 3'd1,
      ST_FEED  = 3'd2,
      ST_DRAIN = 3'd3,
      ST_DONE  = 3'd4
   } feeder_state_t;

endpackage

// File: rtl/operand_buffer.sv
// N x N operand store: one synchronous write port and N independent
// combinational read ports, one per array lane.
module operand_buffer
   import tpu_pkg::*;
#(
   parameter int N  = 2,
   parameter int IW = 1
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        we,
   input  logic [IW-1:0]               row,
   input  logic [IW-1:0]               col,
   input  logic [DATA_W-1:0]           data,
   input  logic [N-1:0][IW-1:0]        rd_row,
   input  logic [N-1:0][IW-1:0]        rd_col,
   output logic [N-1:0][DATA_W-1:0]    rd_data
);

   logic [DATA_W-1:0] mem [N][N];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
               mem[r][c] <= '0;
      end else if (we) begin
         mem[row][col] <= data;
      end
   end

   always_comb begin
      rd_data = '0;
      for (int p = 0; p < N; p++)
         rd_data[p] = mem[rd_row[p]][rd_col[p]];
   end

endmodule

// File: rtl/systolic_feeder.sv
// Loads A and B operand matrices, then streams them into a systolic array
// with the diagonal skew the array needs, followed by a drain period and done.
module systolic_feeder
   import tpu_pkg::*;
#(
   parameter int N         = 2,
   parameter int DRAIN_CYC = 2 * N
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          wr_en,
   input  logic                          wr_sel,
   input  logic [(N>1?$clog2(N):1)-1:0]  wr_row,
   input  logic [(N>1?$clog2(N):1)-1:0]  wr_col,
   input  logic [DATA_W-1:0]             wr_data,
   input  logic                          start,
   output logic                          busy,
   output logic                          array_rst,
   output logic [N-1:0][DATA_W-1:0]      a_out,
   output logic [N-1:0][DATA_W-1:0]      b_out,
   output logic                          done,
   output feeder_state_t                 fsm_state
);

   localparam int IW   = (N > 1) ? $clog2(N) : 1;
   localparam int CMAX = (2 * N - 1 > DRAIN_CYC) ? 2 * N - 1 : DRAIN_CYC;
   localparam int CW   = (CMAX > 1) ? $clog2(CMAX + 1) : 1;
   localparam logic [CW-1:0] FEED_LAST  = CW'(2 * N - 2);
   localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_CYC - 1);

   feeder_state_t state;
   logic [CW-1:0] cnt;

   logic                     we_a, we_b;
   logic [N-1:0]             lane_ok;
   logic [N-1:0][IW-1:0]     a_row, a_col, b_row, b_col;
   logic [N-1:0][DATA_W-1:0] a_rd, b_rd;

   // cnt is the FEED step t, then reused to time the DRAIN period.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               cnt <= '0;
               if (start) state <= ST_CLEAR;
            end
            ST_CLEAR: begin
               cnt   <= '0;
               state <= ST_FEED;
            end
            ST_FEED: begin
               if (cnt == FEED_LAST) begin
                  cnt   <= '0;
                  state <= ST_DRAIN;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            ST_DRAIN: begin
               if (cnt == DRAIN_LAST) begin
                  cnt   <= '0;
                  state <= ST_DONE;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            ST_DONE: begin
               cnt   <= '0;
               state <= ST_IDLE;
            end
            default: begin
               cnt   <= '0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign we_a = wr_en && !wr_sel && (state == ST_IDLE);
   assign we_b = wr_en &&  wr_sel && (state == ST_IDLE);

   // Lane i carries element k = t - i: A[i][k] on rows, B[k][i] on columns.
   always_comb begin
      lane_ok = '0;
      a_row   = '0;
      a_col   = '0;
      b_row   = '0;
      b_col   = '0;
      for (int i = 0; i < N; i++) begin
         a_row[i] = IW'(i);
         b_col[i] = IW'(i);
         if (state == ST_FEED && int'(cnt) >= i && int'(cnt) - i < N) begin
            lane_ok[i] = 1'b1;
            a_col[i]   = IW'(int'(cnt) - i);
            b_row[i]   = IW'(int'(cnt) - i);
         end
      end
   end

   always_comb begin
      a_out = '0;
      b_out = '0;
      for (int i = 0; i < N; i++) begin
         if (lane_ok[i]) begin
            a_out[i] = a_rd[i];
            b_out[i] = b_rd[i];
         end
      end
   end

   operand_buffer #(.N(N), .IW(IW)) u_buf_a (
      .clk     (clk),
      .reset   (reset),
      .we      (we_a),
      .row     (wr_row),
      .col     (wr_col),
      .data    (wr_data),
      .rd_row  (a_row),
      .rd_col  (a_col),
      .rd_data (a_rd)
   );

   operand_buffer #(.N(N), .IW(IW)) u_buf_b (
      .clk     (clk),
      .reset   (reset),
      .we      (we_b),
      .row     (wr_row),
      .col     (wr_col),
      .data    (wr_data),
      .rd_row  (b_row),
      .rd_col  (b_col),
      .rd_data (b_rd)
   );

   assign busy      = (state != ST_IDLE);
   assign array_rst = (state == ST_CLEAR);
   assign done      = (state == ST_DONE);
   assign fsm_state = state;

endmodule

// File: tb/tb_systolic_feeder.sv
// Self-checking bench for systolic_feeder: matrix table, skewed-operand
// scoreboard, product reconstruction, and control corner cases.
module tb_systolic_feeder;
   import tpu_pkg::*;

   localparam int N     = 2;
   localparam int DRAIN = 2 * N;
   localparam int FEEDN = 2 * N - 1;
   localparam int LAT   = 1 + 1 + FEEDN + DRAIN;

   logic                clk = 1'b0;
   logic                reset;
   logic                wr_en;
   logic                wr_sel;
   logic [0:0]          wr_row, wr_col;
   logic [15:0]         wr_data;
   logic                start;
   logic                busy, array_rst, done;
   logic [N-1:0][15:0]  a_out, b_out;
   feeder_state_t       fsm_state;

   typedef struct {
      int a[4];
      int b[4];
      int c[4];
   } vec_t;

   vec_t        tbl[4];
   int          mdl_a[N][N];
   int          mdl_b[N][N];
   int          a_hist[FEEDN][N];
   int          b_hist[FEEDN][N];
   logic [63:0] exp_q[$];
   int          n_checks = 0;
   int          n_fail   = 0;

   systolic_feeder #(.N(N), .DRAIN_CYC(DRAIN)) dut (
      .clk       (clk),
      .reset     (reset),
      .wr_en     (wr_en),
      .wr_sel    (wr_sel),
      .wr_row    (wr_row),
      .wr_col    (wr_col),
      .wr_data   (wr_data),
      .start     (start),
      .busy      (busy),
      .array_rst (array_rst),
      .a_out     (a_out),
      .b_out     (b_out),
      .done      (done),
      .fsm_state (fsm_state)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_elem(input bit sel, input int row, input int col, input int data);
      wr_en   = 1'b1;
      wr_sel  = sel;
      wr_row  = 1'(row);
      wr_col  = 1'(col);
      wr_data = 16'(data);
      tick();
      wr_en = 1'b0;
      if (sel) mdl_b[row][col] = data & 16'hffff;
      else     mdl_a[row][col] = data & 16'hffff;
   endtask

   task automatic load(input vec_t v);
      for (int k = 0; k < 4; k++) begin
         write_elem(1'b0, k / 2, k % 2, v.a[k]);
         write_elem(1'b1, k / 2, k % 2, v.b[k]);
      end
   endtask

   // mode 0: plain run; 1: start+write pulsed mid-FEED; 2: write A[1][1]=9 with start.
   task automatic run_mult(input int mode, input int c00, input int c01, input int c10, input int c11);
      logic [63:0] e;
      logic [63:0] got;
      int          acc;
      int          cexp[4];
      cexp = '{c00, c01, c10, c11};
      if (mode == 2) begin
         wr_en = 1'b1; wr_sel = 1'b0; wr_row = 1'b1; wr_col = 1'b1; wr_data = 16'd9;
         mdl_a[1][1] = 9;
      end
      for (int t = 0; t < FEEDN; t++) begin
         e = '0;
         for (int i = 0; i < N; i++) begin
            if (t - i >= 0 && t - i < N) begin
               e[16*i +: 16]      = 16'(mdl_a[i][t-i]);
               e[32 + 16*i +: 16] = 16'(mdl_b[t-i][i]);
            end
         end
         exp_q.push_back(e);
      end
      start = 1'b1;
      tick();
      start = 1'b0;
      wr_en = 1'b0;
      check("clear_array_rst", 64'(array_rst), 64'd1);
      check("clear_busy", 64'(busy), 64'd1);
      check("clear_ops_zero", {b_out, a_out}, 64'd0);
      for (int k = 2; k <= LAT; k++) begin
         tick();
         start = 1'b0;
         wr_en = 1'b0;
         got = {b_out, a_out};
         if (k < 2 + FEEDN) begin
            if (exp_q.size() == 0) begin
               check("feed_queue_underflow", 64'd1, 64'd0);
            end else begin
               e = exp_q.pop_front();
               check($sformatf("feed_t%0d_ops", k - 2), got, e);
            end
            for (int i = 0; i < N; i++) begin
               a_hist[k-2][i] = int'(a_out[i]);
               b_hist[k-2][i] = int'(b_out[i]);
            end
         end else begin
            check($sformatf("idle_ops_c%0d", k), got, 64'd0);
         end
         check($sformatf("array_rst_c%0d", k), 64'(array_rst), 64'd0);
         check($sformatf("done_c%0d", k), 64'(done), 64'(k == LAT));
         check($sformatf("busy_c%0d", k), 64'(busy), 64'd1);
         if (mode == 1 && k == 3) begin
            start = 1'b1;
            wr_en = 1'b1; wr_sel = 1'b0; wr_row = 1'b0; wr_col = 1'b0; wr_data = 16'd777;
         end
      end
      tick();
      check("post_busy", 64'(busy), 64'd0);
      check("post_done", 64'(done), 64'd0);
      check("post_state", 64'(fsm_state), 64'(ST_IDLE));
      check("queue_drained", 64'(exp_q.size()), 64'd0);
      // PE(i,j) sees row stream i delayed j and column stream j delayed i.
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            acc = 0;
            for (int k = 0; k < N; k++)
               acc += a_hist[k+i][i] * b_hist[k+j][j];
            check($sformatf("result_c%0d%0d", i, j), 64'(acc), 64'(cexp[i*N+j]));
         end
      end
      exp_q.delete();
   endtask

   initial begin : main
      int c[4];
      bit done_seen;
      tbl[0] = '{a: '{1, 2, 3, 4},         b: '{5, 6, 7, 8}, c: '{19, 22, 43, 50}};
      tbl[1] = '{a: '{1, 0, 0, 1},         b: '{9, 8, 7, 6}, c: '{9, 8, 7, 6}};
      tbl[2] = '{a: '{2, 3, 4, 5},         b: '{1, 1, 1, 1}, c: '{5, 5, 9, 9}};
      tbl[3] = '{a: '{100, 200, 300, 400}, b: '{2, 0, 0, 3}, c: '{200, 600, 600, 1200}};

      reset = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; wr_row = '0; wr_col = '0;
      wr_data = '0; start = 1'b0;
      for (int r = 0; r < N; r++)
         for (int q = 0; q < N; q++) begin
            mdl_a[r][q] = 0;
            mdl_b[r][q] = 0;
         end
      tick();
      tick();
      check("reset_busy", 64'(busy), 64'd0);
      check("reset_array_rst", 64'(array_rst), 64'd0);
      check("reset_done", 64'(done), 64'd0);
      check("reset_ops", {b_out, a_out}, 64'd0);
      check("reset_state", 64'(fsm_state), 64'(ST_IDLE));
      reset = 1'b0;
      tick();

      for (int v = 0; v < 4; v++) begin
         load(tbl[v]);
         run_mult(0, tbl[v].c[0], tbl[v].c[1], tbl[v].c[2], tbl[v].c[3]);
      end

      // Back-to-back starts without rewriting, then a mid-FEED poke.
      load(tbl[0]);
      run_mult(0, 19, 22, 43, 50);
      run_mult(0, 19, 22, 43, 50);
      run_mult(1, 19, 22, 43, 50);
      run_mult(0, 19, 22, 43, 50);

      // Write in the start cycle is visible to FEED.
      run_mult(2, 19, 22, 78, 90);

      // Random operands, product computed here.
      for (int k = 0; k < 4; k++) begin
         write_elem(1'b0, k / 2, k % 2, int'($urandom_range(0, 255)));
         write_elem(1'b1, k / 2, k % 2, int'($urandom_range(0, 255)));
      end
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) begin
            c[i*N+j] = 0;
            for (int k = 0; k < N; k++)
               c[i*N+j] += mdl_a[i][k] * mdl_b[k][j];
         end
      run_mult(0, c[0], c[1], c[2], c[3]);

      // Reset at FEED t=1 aborts and clears both buffers.
      load(tbl[0]);
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      check("pre_abort_ops", {b_out, a_out}, {16'd6, 16'd7, 16'd3, 16'd2});
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("abort_state", 64'(fsm_state), 64'(ST_IDLE));
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_ops", {b_out, a_out}, 64'd0);
      check("abort_rst_done", {62'd0, array_rst, done}, 64'd0);
      done_seen = 1'b0;
      for (int k = 0; k < LAT + 4; k++) begin
         tick();
         if (done) done_seen = 1'b1;
      end
      check("abort_no_done", 64'(done_seen), 64'd0);
      for (int r = 0; r < N; r++)
         for (int q = 0; q < N; q++) begin
            mdl_a[r][q] = 0;
            mdl_b[r][q] = 0;
         end
      run_mult(0, 0, 0, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/systolic_feeder.md
SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

Interface
REQ-001 Parameter: N, default 2, array dimension; operands are N x N matrices.
REQ-002 Parameter: DRAIN_CYC, default 2*N, idle cycles after the last operand before done.
REQ-003 Port: clk  in  1  single clock; all logic on rising edge.
REQ-004 Port: reset  in  1  synchronous, active-high reset.
REQ-005 Port: wr_en  in  1  operand write strobe.
REQ-006 Port: wr_sel  in  1  target matrix: 0 = A, 1 = B.
REQ-007 Port: wr_row, wr_col  in  clog2(N) each  element index.
REQ-008 Port: wr_data  in  16  operand value.
REQ-009 Port: start  in  1  single-cycle pulse that launches one matrix multiply.
REQ-010 Port: busy  out  1  high in every state except IDLE.
REQ-011 Port: array_rst  out  1  accumulator clear for the downstream systolic_array reset input.
REQ-012 Port: a_out  out  16 x N  skewed row operands, element i to array row i.
REQ-013 Port: b_out  out  16 x N  skewed column operands, element j to array column j.
REQ-014 Port: done  out  1  one-cycle pulse; array results are valid from this cycle on.

Function
REQ-015 Two N x N 16-bit buffers SHALL hold A and B; a write in IDLE SHALL store wr_data at [wr_row][wr_col] of the selected buffer on that edge.
REQ-016 Writes while busy=1 SHALL be ignored, leaving the buffers unchanged.
REQ-017 FSM states SHALL be IDLE, CLEAR, FEED, DRAIN and DONE.
REQ-018 IDLE->CLEAR SHALL occur on start=1; start while busy=1 SHALL be ignored.
REQ-019 CLEAR SHALL last 1 cycle with array_rst=1; array_rst SHALL be 0 in all other states.
REQ-020 FEED SHALL last 2N-1 cycles with a step counter t = 0..2N-2.
REQ-021 In FEED, a_out[i] SHALL be A[i][t-i] when 0 <= t-i < N, else 0.
REQ-022 In FEED, b_out[j] SHALL be B[t-j][j] when 0 <= t-j < N, else 0.
REQ-023 a_out and b_out SHALL be 0 in IDLE, CLEAR, DRAIN and DONE.
REQ-024 DRAIN SHALL last DRAIN_CYC cycles; DONE SHALL last 1 cycle with done=1 and then return to IDLE.
REQ-025 A write and a start in the same IDLE cycle SHALL both be accepted, and FEED SHALL use the newly written value.
REQ-026 Total latency from start to done SHALL be 1 + 1 + (2N-1) + DRAIN_CYC cycles, with start sampled in IDLE.
REQ-027 Buffers SHALL retain their contents after DONE, so a repeated start recomputes the same product.

Reset
REQ-028 reset SHALL force IDLE, t=0, both buffers to 0, and busy=0, array_rst=0, done=0, a_out=0, b_out=0 on the next edge.
REQ-029 reset in any state, including mid-FEED, SHALL abort the operation, produce no done pulse, and take priority over start and wr_en.

Structure
REQ-030 Shared package tpu_pkg SHALL hold DATA_W=16, ACC_W=32 and the feeder state enum.
REQ-031 One sub-module, operand_buffer (N x N storage with write port and combinational read by index), SHALL be instantiated twice, once for A and once for B.

Verification
REQ-032 N=2, write A=[[1,2],[3,4]] and B=[[5,6],[7,8]], then start -> CLEAR cycle with array_rst=1, then FEED t0: a=(1,0) b=(5,0); t1: a=(2,3) b=(7,6); t2: a=(0,4) b=(0,8).
REQ-033 Same run driving systolic_array -> done exactly 1+1+3+4=9 cycles after start; result = [[19,22],[43,50]].
REQ-034 Pulse start and wr_en during FEED -> no restart, buffers unchanged, done still arrives at cycle 9.
REQ-035 Assert reset at FEED t=1 -> next cycle state IDLE, all outputs 0, buffers 0, and no done pulse.
REQ-036 Write A[1][1]=9 in the same cycle as start -> t2 presents a_out[1]=9.
REQ-037 Two back-to-back starts with no rewrite -> identical operand sequences and identical results.
